rv32i_instr_encoder: RTL and testbench

RV32I_INSTR_ENCODER -- requirements
Module: rv32i_instr_encoder

---
 rtl/rv32i_instr_encoder.sv | 181 ++++++++++++++++++
 tb/tb_rv32i_instr_encoder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction encoder: combinational field packing into a 2-entry output FIFO,
// with accepted/illegal request counters.
module rv32i_instr_encoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_class,
    input  logic [3:0]       in_alu_op,
    input  logic [2:0]       in_funct3,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_illegal,
    output logic [CNT_W-1:0] accepted_cnt,
    output logic [7:0]       illegal_cnt
);

    typedef enum logic [2:0] {
        CLS_R_ALU  = 3'd0,
        CLS_I_ALU  = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JAL    = 3'd5,
        CLS_JALR   = 3'd6,
        CLS_RSVD   = 3'd7
    } instr_class_e;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_SLTU = 4'b1010
    } alu_op_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [2:0]  w_alu_f3;
    logic [6:0]  w_alu_f7;
    logic        w_alu_ok;
    logic        w_alu_shift;
    logic [11:0] w_i_imm;
    logic [31:0] w_instr;
    logic        w_illegal;
    logic        w_push;
    logic        w_pop;

    logic [31:0] r_mem_instr [2];
    logic        r_mem_ill   [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic [CNT_W-1:0] r_acc_cnt;
    logic [7:0]  r_ill_cnt;

    always_comb begin
        w_alu_f3    = 3'b000;
        w_alu_f7    = 7'h00;
        w_alu_ok    = 1'b1;
        w_alu_shift = 1'b0;
        case (in_alu_op)
            ALU_ADD:  w_alu_f3 = 3'b000;
            ALU_SUB:  begin w_alu_f3 = 3'b000; w_alu_f7 = 7'h20; end
            ALU_SLL:  begin w_alu_f3 = 3'b001; w_alu_shift = 1'b1; end
            ALU_SLT:  w_alu_f3 = 3'b010;
            ALU_SLTU: w_alu_f3 = 3'b011;
            ALU_XOR:  w_alu_f3 = 3'b100;
            ALU_SRL:  begin w_alu_f3 = 3'b101; w_alu_shift = 1'b1; end
            ALU_SRA:  begin w_alu_f3 = 3'b101; w_alu_f7 = 7'h20; w_alu_shift = 1'b1; end
            ALU_OR:   w_alu_f3 = 3'b110;
            ALU_AND:  w_alu_f3 = 3'b111;
            default:  w_alu_ok = 1'b0;
        endcase
    end

    // Shift immediates carry only shamt; the upper 7 bits reuse funct7 to tell srai from srli.
    assign w_i_imm = w_alu_shift ? {w_alu_f7, in_imm[4:0]} : in_imm[11:0];

    always_comb begin
        w_instr   = '0;
        w_illegal = 1'b0;
        case (in_class)
            CLS_R_ALU: begin
                w_illegal = !w_alu_ok;
                w_instr   = {w_alu_f7, in_rs2, in_rs1, w_alu_f3, in_rd, OP_R};
            end
            CLS_I_ALU: begin
                w_illegal = !w_alu_ok || (in_alu_op == ALU_SUB);
                w_instr   = {w_i_imm, in_rs1, w_alu_f3, in_rd, OP_I};
            end
            CLS_LOAD: begin
                w_illegal = (in_funct3 == 3'b011) || (in_funct3 == 3'b110) ||
                            (in_funct3 == 3'b111);
                w_instr   = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            end
            CLS_STORE: begin
                w_illegal = (in_funct3 > 3'b010);
                w_instr   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
            end
            CLS_BRANCH: begin
                w_illegal = (in_funct3 == 3'b010) || (in_funct3 == 3'b011);
                w_instr   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], OP_BRANCH};
            end
            CLS_JAL: begin
                w_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
            end
            CLS_JALR: begin
                w_instr = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        if (w_illegal) begin
            w_instr = '0;
        end
    end

    assign in_ready  = (r_count < 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_ill[i]   <= 1'b0;
            end
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= '0;
            r_acc_cnt <= '0;
            r_ill_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem_instr[r_wr_ptr] <= w_instr;
                r_mem_ill[r_wr_ptr]   <= w_illegal;
                r_wr_ptr  <= !r_wr_ptr;
                r_acc_cnt <= r_acc_cnt + 1'b1;
                if (w_illegal && (r_ill_cnt != 8'hFF)) begin
                    r_ill_cnt <= r_ill_cnt + 8'd1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_instr    = out_valid ? r_mem_instr[r_rd_ptr] : '0;
    assign out_illegal  = out_valid ? r_mem_ill[r_rd_ptr]   : 1'b0;
    assign accepted_cnt = r_acc_cnt;
    assign illegal_cnt  = r_ill_cnt;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Directed self-checking bench for rv32i_instr_encoder with hand-computed encodings.
module tb_rv32i_instr_encoder;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_class;
    logic [3:0]       in_alu_op;
    logic [2:0]       in_funct3;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_illegal;
    logic [CNT_W-1:0] accepted_cnt;
    logic [7:0]       illegal_cnt;

    int unsigned      checks;
    int unsigned      failures;
    logic [CNT_W-1:0] exp_acc;
    logic [7:0]       exp_ill;

    rv32i_instr_encoder #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_class     (in_class),
        .in_alu_op    (in_alu_op),
        .in_funct3    (in_funct3),
        .in_rd        (in_rd),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_imm       (in_imm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_illegal  (out_illegal),
        .accepted_cnt (accepted_cnt),
        .illegal_cnt  (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cls;
        logic [3:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    task automatic drive(input vec_t v);
        in_class  = v.cls;
        in_alu_op = v.op;
        in_funct3 = v.f3;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_imm    = v.imm;
        in_valid  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_class = '0; in_alu_op = '0; in_funct3 = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        exp_acc = '0; exp_ill = '0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0 ||
            out_illegal !== 1'b0 || accepted_cnt !== '0 || illegal_cnt !== 8'h0) begin
            failures++;
            $display("FAIL reset_state: valid=%b ready=%b instr=%h ill=%b acc=%0d illc=%0d, want 0 1 0 0 0 0",
                     out_valid, in_ready, out_instr, out_illegal, accepted_cnt, illegal_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single request with out_ready high: word must be at the head one cycle after acceptance.
    task automatic run_single(input string name, input vec_t v);
        @(negedge clk);
        out_ready = 1'b1;
        drive(v);
        @(negedge clk);
        in_valid = 1'b0;
        exp_acc = exp_acc + 1'b1;
        if (v.ill && exp_ill != 8'hFF) exp_ill = exp_ill + 8'd1;
        checks++;
        if (out_valid !== 1'b1 || out_instr !== v.exp || out_illegal !== v.ill) begin
            failures++;
            $display("FAIL %s: valid=%b instr=%h ill=%b, want 1 %h %b",
                     name, out_valid, out_instr, out_illegal, v.exp, v.ill);
        end
    endtask

    task automatic test_encode();
        vec_t v [8];
        string n [8];
        v[0] = '{3'd0, 4'b0010, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0}; n[0] = "r_add";
        v[1] = '{3'd0, 4'b0110, 3'd0, 5'd5, 5'd6, 5'd7, 32'd0, 32'h407302B3, 1'b0}; n[1] = "r_sub";
        v[2] = '{3'd1, 4'b0010, 3'd0, 5'd1, 5'd0, 5'd9, 32'd5, 32'h00500093, 1'b0}; n[2] = "i_addi";
        v[3] = '{3'd4, 4'b0000, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h00208463, 1'b0}; n[3] = "beq";
        v[4] = '{3'd5, 4'b0000, 3'd0, 5'd1, 5'd0, 5'd0, 32'd8, 32'h008000EF, 1'b0}; n[4] = "jal";
        v[5] = '{3'd3, 4'b0000, 3'd2, 5'd0, 5'd2, 5'd3, 32'd4, 32'h00312223, 1'b0}; n[5] = "sw";
        v[6] = '{3'd2, 4'b0000, 3'd2, 5'd5, 5'd2, 5'd0, 32'hFFFF_FFFC, 32'hFFC12283, 1'b0}; n[6] = "lw_neg";
        v[7] = '{3'd1, 4'b1001, 3'd0, 5'd1, 5'd1, 5'd0, 32'hFFFF_FFE3, 32'h4030D093, 1'b0}; n[7] = "srai_trunc";
        for (int i = 0; i < 8; i++) run_single(n[i], v[i]);
        checks++;
        if (accepted_cnt !== exp_acc) begin
            failures++;
            $display("FAIL encode_acc_cnt: got %0d want %0d", accepted_cnt, exp_acc);
        end
    endtask

    task automatic test_illegal();
        vec_t v [5];
        string n [5];
        v[0] = '{3'd1, 4'b0110, 3'd0, 5'd1, 5'd2, 5'd3, 32'd7, 32'h0, 1'b1}; n[0] = "ill_i_sub";
        v[1] = '{3'd3, 4'b0000, 3'd3, 5'd1, 5'd2, 5'd3, 32'd4, 32'h0, 1'b1}; n[1] = "ill_store_f3";
        v[2] = '{3'd7, 4'b0010, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0, 1'b1}; n[2] = "ill_class7";
        v[3] = '{3'd2, 4'b0000, 3'd6, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0, 1'b1}; n[3] = "ill_load_f3";
        v[4] = '{3'd0, 4'b1111, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0, 1'b1}; n[4] = "ill_alu_op";
        for (int i = 0; i < 5; i++) run_single(n[i], v[i]);
        checks++;
        if (illegal_cnt !== exp_ill || accepted_cnt !== exp_acc) begin
            failures++;
            $display("FAIL illegal_counts: illc=%0d acc=%0d want %0d %0d",
                     illegal_cnt, accepted_cnt, exp_ill, exp_acc);
        end
    endtask

    task automatic test_back_to_back();
        vec_t a, b, c;
        a = '{3'd0, 4'b0010, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0};
        b = '{3'd0, 4'b0110, 3'd0, 5'd5, 5'd6, 5'd7, 32'd0, 32'h407302B3, 1'b0};
        c = '{3'd1, 4'b0010, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0};
        @(negedge clk);
        out_ready = 1'b0;
        drive(a);
        @(negedge clk);
        drive(b);
        @(negedge clk);
        drive(c);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== a.exp) begin
            failures++;
            $display("FAIL b2b_full: ready=%b valid=%b instr=%h want 0 1 %h",
                     in_ready, out_valid, out_instr, a.exp);
        end
        @(negedge clk);
        checks++;
        if (out_instr !== a.exp || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stall_stable: instr=%h ready=%b want %h 0", out_instr, in_ready, a.exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_instr !== b.exp || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: instr=%h ready=%b want %h 1", out_instr, in_ready, b.exp);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_instr !== c.exp) begin
            failures++;
            $display("FAIL b2b_third: valid=%b instr=%h want 1 %h", out_valid, out_instr, c.exp);
        end
        @(negedge clk);
        exp_acc = exp_acc + 3'd3;
        checks++;
        if (out_valid !== 1'b0 || accepted_cnt !== exp_acc) begin
            failures++;
            $display("FAIL b2b_drained: valid=%b acc=%0d want 0 %0d", out_valid, accepted_cnt, exp_acc);
        end
    endtask

    task automatic test_saturate();
        vec_t v;
        v = '{3'd4, 4'b0000, 3'd2, 5'd0, 5'd1, 5'd2, 32'd0, 32'h0, 1'b1};
        @(negedge clk);
        out_ready = 1'b1;
        drive(v);
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            exp_acc = exp_acc + 1'b1;
            if (exp_ill != 8'hFF) exp_ill = exp_ill + 8'd1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (illegal_cnt !== 8'hFF || illegal_cnt !== exp_ill) begin
            failures++;
            $display("FAIL illegal_saturate: got %0d want 255", illegal_cnt);
        end
        checks++;
        if (accepted_cnt !== exp_acc) begin
            failures++;
            $display("FAIL acc_wrap: got %0d want %0d", accepted_cnt, exp_acc);
        end
    endtask

    task automatic test_reset_mid();
        vec_t a, b;
        a = '{3'd6, 4'b0000, 3'd0, 5'd1, 5'd2, 5'd0, 32'h0000_0FF0, 32'hFF0100E7, 1'b0};
        b = '{3'd0, 4'b0000, 3'd0, 5'd4, 5'd5, 5'd6, 32'd0, 32'h0062F233, 1'b0};
        @(negedge clk);
        out_ready = 1'b0;
        drive(a);
        @(negedge clk);
        drive(b);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_instr !== a.exp) begin
            failures++;
            $display("FAIL jalr_buffered: ready=%b instr=%h want 0 %h", in_ready, out_instr, a.exp);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0 ||
            accepted_cnt !== '0 || illegal_cnt !== 8'h0) begin
            failures++;
            $display("FAIL async_reset: valid=%b ready=%b instr=%h acc=%0d illc=%0d want 0 1 0 0 0",
                     out_valid, in_ready, out_instr, accepted_cnt, illegal_cnt);
        end
        exp_acc = '0;
        exp_ill = '0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(b);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_instr !== b.exp || accepted_cnt !== 4'd1) begin
            failures++;
            $display("FAIL post_reset_accept: valid=%b instr=%h acc=%0d want 1 %h 1",
                     out_valid, out_instr, accepted_cnt, b.exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_encode();
        test_illegal();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
